// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB requester-side arbiter.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_e;

  // Index width for n items, never less than 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the requester-side arbiter and the completer bridge.
interface apb_master_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0]    pwdata;
  logic [DATA_WIDTH-1:0]    prdata;
  logic                     pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible bit at or above ptr, wrapping.
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan NUM_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos     = (32'(ptr) + off) % NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!any_grant && eligible[pos_idx]) begin
        grant[pos_idx] = 1'b1;
        grant_idx      = pos_idx;
        any_grant      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB requester-side controller: round-robin share of one APB completer port
// among NUM_REQ requesters, sequencing IDLE/SETUP/ACCESS with registered outputs.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                            pclk,
  input  logic                            preset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              done,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  apb_master_arbiter_if.master            apb
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  apb_state_e               state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_REQ-1:0]       win_q, win_d;
  logic                     psel_q, psel_d;
  logic                     penable_q, penable_d;
  logic                     pwrite_q, pwrite_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]       done_q, done_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [IDX_W-1:0]         ptr_next;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned      CNT_W     = clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;

  // A requester whose done is showing this cycle is masked out of arbitration.
  assign eligible = req & ~done_q;
  assign ptr_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Next-state and next-output computation; every output is the registered
  // value for the state being entered.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    win_d     = win_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    rdata_d   = '0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      APB_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (any_grant) begin
          state_d  = APB_SETUP;
          idx_d    = grant_idx;
          win_d    = grant;
          psel_d   = 1'b1;
          pwrite_d = req_write[grant_idx];
          paddr_d  = req_addr[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          pwdata_d = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      APB_SETUP: begin
        state_d   = APB_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      APB_ACCESS: begin
        if (apb.pready) begin
          state_d   = APB_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = win_q;
          rdata_d   = pwrite_q ? '0 : apb.prdata;
          ptr_d     = ptr_next;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_LIMIT) begin
          state_d   = APB_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = win_q;
          err_d     = 1'b1;
          ptr_d     = ptr_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d   = APB_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= APB_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      win_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      win_q     <= win_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign done        = done_q;
  assign rsp_rdata   = rdata_q;
`ifdef APB_TIMEOUT_EN
  assign rsp_err     = err_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic            pclk = 1'b0;
  logic            preset;
  logic [N-1:0]    req, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  apb_master_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  apb_master_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDRESS_WIDTH  (AW),
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (bus)
  );

  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  // Model: one transfer at a time; age counts cycles since the grant edge.
  int            m_ptr, m_win, m_age, m_acc;
  bit            m_busy;
  logic          e_psel, e_pen, e_pwrite, e_err;
  logic [AW-1:0] e_paddr;
  logic [DW-1:0] e_pwdata, e_rdata;
  logic [N-1:0]  e_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_win = 0; m_age = 0; m_acc = 0; m_busy = 0;
    e_psel = 0; e_pen = 0; e_pwrite = 0; e_err = 0;
    e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_done = '0;
  endtask

  task automatic model_step();
    logic [N-1:0]  elig, nd;
    logic [DW-1:0] nrd;
    logic          nerr, fin, found;
    nd = '0; nrd = '0; nerr = 0; fin = 0;
    if (!m_busy) begin
      elig  = req & ~e_done;
      found = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!found && elig[i]) begin
          found = 1;
          m_win = i;
        end
      end
      if (found) begin
        m_busy   = 1;
        m_age    = 1;
        e_psel   = 1;
        e_pen    = 0;
        e_pwrite = req_write[m_win];
        e_paddr  = req_addr[m_win*AW +: AW];
        e_pwdata = req_wdata[m_win*DW +: DW];
      end else begin
        e_psel = 0;
        e_pen  = 0;
      end
    end else if (m_age == 1) begin
      m_age = 2;
      e_pen = 1;
      m_acc = 0;
    end else if (bus.pready) begin
      fin = 1;
      nrd = e_pwrite ? '0 : bus.prdata;
    end else if (TO_ON && m_acc == TO - 1) begin
      fin  = 1;
      nerr = 1;
    end else begin
      m_acc++;
    end
    if (fin) begin
      m_busy    = 0;
      e_psel    = 0;
      e_pen     = 0;
      nd[m_win] = 1'b1;
      m_ptr     = (m_win + 1) % N;
    end
    e_done  = nd;
    e_rdata = nrd;
    e_err   = nerr;
  endtask

  task automatic compare();
    chk("psel",      bus.psel,    e_psel);
    chk("penable",   bus.penable, e_pen);
    chk("pwrite",    bus.pwrite,  e_pwrite);
    chk("paddr",     bus.paddr,   e_paddr);
    chk("pwdata",    bus.pwdata,  e_pwdata);
    chk("done",      done,        e_done);
    chk("rsp_rdata", rsp_rdata,   e_rdata);
    chk("rsp_err",   rsp_err,     e_err);
  endtask

  // Advance one clock: model at the rising edge, compare at the falling edge.
  task automatic cycle();
    @(posedge pclk);
    if (preset) model_reset();
    else model_step();
    @(negedge pclk);
    compare();
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]                = 1'b1;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic drain();
    req        = '0;
    bus.pready = 1'b1;
    repeat (4) cycle();
  endtask

  task automatic do_reset();
    preset = 1'b1;
    req    = '0;
    repeat (2) cycle();
    preset = 1'b0;
  endtask

  int           order[8];
  int           n_got, n_acc, stall;
  logic [N-1:0] seen[2];

  initial begin
    preset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    bus.pready = 1'b0; bus.prdata = '0;
    model_reset();
    repeat (2) cycle();
    chk("reset_psel",    bus.psel,    1'b0);
    chk("reset_penable", bus.penable, 1'b0);
    chk("reset_done",    done,        4'b0000);
    chk("reset_rdata",   rsp_rdata,   32'h0);
    preset = 1'b0;

    // Single zero-wait read from requester 2.
    set_req(2, 1'b0, 32'h40, 32'h0);
    bus.pready = 1'b1; bus.prdata = 32'hDEADBEEF;
    cycle();
    chk("t1_psel_c1",    bus.psel,    1'b1);
    chk("t1_penable_c1", bus.penable, 1'b0);
    cycle();
    chk("t1_penable_c2", bus.penable, 1'b1);
    chk("t1_paddr",      bus.paddr,   32'h40);
    cycle();
    chk("t1_done_c3",    done,        4'b0100);
    chk("t1_rdata",      rsp_rdata,   32'hDEADBEEF);

    // Reset during ACCESS of requester 1; pointer would otherwise favour 3.
    req = '0;
    set_req(1, 1'b0, 32'h80, 32'h0);
    bus.pready = 1'b0;
    cycle();
    cycle();
    chk("rst_in_access", bus.penable, 1'b1);
    #2 preset = 1'b1;
    #1;
    chk("rst_async_psel",    bus.psel,    1'b0);
    chk("rst_async_penable", bus.penable, 1'b0);
    chk("rst_async_paddr",   bus.paddr,   32'h0);
    model_reset();
    req = '0;
    cycle();
    preset = 1'b0;
    set_req(0, 1'b1, 32'h4, 32'hA);
    set_req(1, 1'b0, 32'h8, 32'h0);
    set_req(3, 1'b1, 32'hC, 32'hB);
    bus.pready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 10 && n_got == 0; c++) begin
      cycle();
      if (done != '0) n_got = 1;
    end
    chk("rst_first_grant", done, 4'b0001);
    drain();

    // Write from requester 0 with three wait-state ACCESS cycles.
    set_req(0, 1'b1, 32'h10, 32'h12345678);
    bus.pready = 1'b0;
    repeat (4) cycle();
    chk("wr_paddr_held",  bus.paddr,   32'h10);
    chk("wr_pwdata_held", bus.pwdata,  32'h12345678);
    chk("wr_penable",     bus.penable, 1'b1);
    bus.pready = 1'b1;
    cycle();
    chk("wr_done", done,      4'b0001);
    chk("wr_rd0",  rsp_rdata, 32'h0);
    drain();

    // All four requesters held high: strict rotation from 0.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i * 16), DW'(i + 100));
    bus.pready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 40 && n_got < 8; c++) begin
      cycle();
      for (int i = 0; i < N; i++)
        if (done[i] && n_got < 8) begin
          order[n_got] = i;
          n_got++;
        end
    end
    chk("rr_count", 64'(n_got), 64'd8);
    for (int k = 0; k < 8; k++) chk($sformatf("rr_order%0d", k), 64'(order[k]), 64'(k % 4));
    drain();

    // Requester 3 stays high after done; requester 1 is served before it again.
    do_reset();
    set_req(3, 1'b0, 32'h30, 32'h0);
    bus.pready = 1'b1; bus.prdata = 32'h5555AAAA;
    cycle();
    cycle();
    set_req(1, 1'b0, 32'h14, 32'h0);
    cycle();
    chk("hold3_first", done, 4'b1000);
    n_got = 0;
    for (int c = 0; c < 12 && n_got < 2; c++) begin
      cycle();
      if (done != '0) begin
        seen[n_got] = done;
        n_got++;
      end
    end
    chk("hold3_count", 64'(n_got), 64'd2);
    chk("hold3_next1", seen[0], 4'b0010);
    chk("hold3_next3", seen[1], 4'b1000);
    drain();

`ifdef APB_TIMEOUT_EN
    // Stuck pready: abort after TO ACCESS cycles, then a normal transfer.
    set_req(1, 1'b0, 32'h24, 32'h0);
    bus.pready = 1'b0; bus.prdata = 32'hFFFF0000;
    n_acc = 0; n_got = 0;
    for (int c = 0; c < 40 && n_got == 0; c++) begin
      cycle();
      if (bus.penable) n_acc++;
      if (done != '0) n_got = 1;
    end
    chk("to_access_cycles", 64'(n_acc), 64'(TO));
    chk("to_done",  done,      4'b0010);
    chk("to_err",   rsp_err,   1'b1);
    chk("to_rdata", rsp_rdata, 32'h0);
    req = '0;
    set_req(2, 1'b0, 32'h28, 32'h0);
    bus.pready = 1'b1; bus.prdata = 32'h0BADF00D;
    n_got = 0;
    for (int c = 0; c < 10 && n_got == 0; c++) begin
      cycle();
      if (done != '0) n_got = 1;
    end
    chk("to_next_done", done,      4'b0100);
    chk("to_next_err",  rsp_err,   1'b0);
    chk("to_next_data", rsp_rdata, 32'h0BADF00D);
    drain();
`endif

    // Randomized traffic against the model.
    stall = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        bit infl;
        infl = m_busy && (m_win == i);
        if (e_done[i]) begin
          if ($urandom_range(0, 1) != 0) set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          else req[i] = 1'b0;
        end else if (req[i] && infl && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && !infl && $urandom_range(0, 3) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
      end
      if (stall > 0) begin
        bus.pready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 99) == 0) begin
        bus.pready = 1'b0;
        stall = 20;
      end else begin
        bus.pready = ($urandom_range(0, 2) != 0);
      end
      bus.prdata = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
